timer_pwm_multi: RTL and testbench
==================================

Name: timer_pwm_multi

Overview:
Parametrised memory-mapped counter/timer for the SoC I/O space: 8-bit register bus, WIDTH-bit counter, shared 16-bit prescaler, CHANNELS compare channels.
- Generalises the single 8-bit two-compare timer.
- Adds per-channel outputs with enables, double-buffered compares (glitch-free PWM updates), atomic multi-byte counter reads, and a maskable interrupt with write-1-to-clear flags.
- Top level muxes pwm_out onto GPIO pins where pwm_en is set.

Parameters:
WIDTH, 16, counter/compare width; legal values 8 or 16.
CHANNELS, 2, number of compare channels; legal values 1..4.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
din  input  8  write data
address  input  8  register byte address (block-local)
w_en  input  1  write strobe, one cycle per write
r_en  input  1  read strobe
dout  output  8  registered read data
pwm_out  output  CHANNELS  channel outputs
pwm_en  output  CHANNELS  = OUTEN[CHANNELS-1:0]; top-level pin mux select
irq  output  1  = |(FLAGS & IRQEN), from registered state

Behaviour:
- Reset (async, rst=1): all registers, prescaler, counter, active/buffered compares, outputs, FLAGS, CNT_H snapshot and dout go to 0.
- Register map:
  - 0x00 CTRL: [1:0] mode; 00 idle, 01 CTC, 10 PWM, 11 treated as idle.
  - 0x01 OUTEN.
  - 0x02/0x03 PRESC L/H.
  - 0x04 IRQEN: bit k = channel k match; bit 7 = top/wrap event.
  - 0x05 FLAGS: same bit layout; W1C.
  - 0x06/0x07 CNT L/H: read-only.
  - 0x08+2k / 0x09+2k CMPk L/H, k < CHANNELS.
  - Unmapped reads return 0x00; unmapped writes ignored. With WIDTH=8, all H bytes read 0 and ignore writes.
- Reads: dout updates on the clock edge where r_en=1 (1-cycle latency) and holds otherwise. CMPk reads return the buffered value.
- Atomic count read: reading CNT_L captures counter[WIDTH-1:8] into the snapshot; reading CNT_H returns the snapshot.
- Prescaler:
  - Counts 0..PRESC. A one-cycle tick fires at PRESC, then the prescaler returns to 0. Tick period = PRESC+1 cycles; PRESC=0 gives a tick every cycle.
  - Prescaler is held at 0 in idle.
- Mode change: any CTRL write that changes mode takes effect on the next edge:
  - counter=0, prescaler=0, pwm_out=0;
  - active compares loaded from buffers.
  - First counter advance occurs PRESC+1 cycles after the write edge.
- Compare buffering: CMP writes go to the buffer. Buffer→active transfer is immediate (next edge) in idle/CTC; in PWM it happens only on the tick where counter==MAX.
- Idle: counter=0, pwm_out=0; no flags are set.
- CTC, on each tick:
  - If counter==cmp0: counter<=0, out0 toggles, FLAGS[7] set.
  - Otherwise counter<=counter+1, wrapping at MAX to 0; a cmp0 below the current count is reached after wrap.
  - Channel k>0: out_k toggles on counter==cmpk.
  - FLAGS[k] set on counter==cmpk.
- PWM, on each tick: counter<=counter+1, free-running mod 2^WIDTH.
  - If counter==MAX: all pwm_out<=1, FLAGS[7] set, compares reloaded.
  - Else, per channel: if counter==cmpk then out_k<=0 and FLAGS[k] set.
  - Duty = (cmpk+1)/2^WIDTH; cmpk=MAX gives a constant 1 (set wins at MAX). 0% duty is not achievable; software uses OUTEN=0 and the pin's GPIO value.
- Flags: hardware set and W1C of the same bit on the same edge → the set wins. Writing 0 bits leaves flags unchanged.
- irq is combinational from registers; no extra latency beyond the flag edge.
- pwm_out toggles/sets regardless of OUTEN; OUTEN only drives pwm_en.

Test Plan:
1. Reset mid-PWM (WIDTH=16, CMP0=0x1234, counting) → assert rst: next sample all outputs, dout, irq = 0; CNT reads 0x0000.
2. CTC: WIDTH=8, PRESC=0, CMP0=4, CTRL=01 → out0 toggles every 5 cycles; FLAGS=0x80 after first match; IRQEN=0x80 → irq=1; write FLAGS=0x80 → irq=0.
3. PWM: WIDTH=8, PRESC=1, CMP0=0x3F, CMP1=0xFF → out0 high 128 of 512 cycles; out1 constant 1 after the first wrap.
4. Double buffer: PWM, CMP0 written 0x3F→0xBF mid-period → the current period keeps 0x3F; the next period's duty = 0xC0/256.
5. Atomic read: WIDTH=16, PRESC=0, counter near 0x01FF → read CNT_L=0xFF, then CNT_H a few cycles later returns 0x01, not 0x02.
6. Flag race: W1C of FLAGS[0] on the same edge as a channel 0 match → FLAGS[0] remains 1. Address 0x0C read with CHANNELS=2 → dout=0x00.

Source files
------------

// File: rtl/timer_pwm_multi.sv
// timer_pwm_multi: memory-mapped counter/timer with a shared 16-bit prescaler and CHANNELS compare/PWM outputs.
// Latency: reads return on dout one cycle after r_en; writes take effect on the strobe edge.
// Backpressure: none; the register bus accepts one read or write every cycle.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   din, address, w_en  register write data, byte address, write strobe
//   r_en, dout          read strobe, registered read data (holds between reads)
//   pwm_out             per-channel compare/PWM outputs
//   pwm_en              OUTEN[CHANNELS-1:0], pin mux select at the top level
//   irq                 |(FLAGS & IRQEN)
module timer_pwm_multi #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          din,
  input  logic [7:0]          address,
  input  logic                w_en,
  input  logic                r_en,
  output logic [7:0]          dout,
  output logic [CHANNELS-1:0] pwm_out,
  output logic [CHANNELS-1:0] pwm_en,
  output logic                irq
);

  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

  logic [1:0]          mode_q,  mode_d;
  logic [7:0]          outen_q, outen_d;
  logic [15:0]         presc_q, presc_d;
  logic [7:0]          irqen_q, irqen_d;
  logic [7:0]          flags_q, flags_d;
  logic [15:0]         pcnt_q,  pcnt_d;
  logic [WIDTH-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0]    cmp_buf_q [CHANNELS];
  logic [WIDTH-1:0]    cmp_buf_d [CHANNELS];
  logic [WIDTH-1:0]    cmp_act_q [CHANNELS];
  logic [WIDTH-1:0]    cmp_act_d [CHANNELS];
  logic [CHANNELS-1:0] out_q,   out_d;
  logic [7:0]          snap_q,  snap_d;
  logic [7:0]          dout_q,  dout_d;

  logic        ctc_mode, pwm_mode, running, tick, mode_chg;
  logic [7:0]  flag_set;
  logic [7:0]  rdata;
  logic [15:0] cnt16, wb16, rb16;

  assign cnt16    = 16'(cnt_q);
  assign ctc_mode = (mode_q == 2'b01);
  assign pwm_mode = (mode_q == 2'b10);
  assign running  = ctc_mode | pwm_mode;
  // >= rather than == so that lowering PRESC below the running prescaler
  // count ticks immediately instead of waiting for a 16-bit wrap.
  assign tick     = running && (pcnt_q >= presc_q);
  assign mode_chg = w_en && (address == 8'h00) && (din[1:0] != mode_q);

  // Register-file writes (compares land in the buffers only)
  always_comb begin
    mode_d    = mode_q;
    outen_d   = outen_q;
    presc_d   = presc_q;
    irqen_d   = irqen_q;
    cmp_buf_d = cmp_buf_q;
    wb16      = '0;
    if (w_en) begin
      case (address)
        8'h00:   mode_d        = din[1:0];
        8'h01:   outen_d       = din;
        8'h02:   presc_d[7:0]  = din;
        8'h03:   presc_d[15:8] = din;
        8'h04:   irqen_d       = din;
        default: ;
      endcase
      for (int k = 0; k < CHANNELS; k++) begin
        if (address == 8'(8 + 2 * k)) begin
          wb16          = 16'(cmp_buf_q[k]);
          wb16[7:0]     = din;
          cmp_buf_d[k]  = wb16[WIDTH-1:0];
        end else if ((WIDTH == 16) && (address == 8'(9 + 2 * k))) begin
          wb16          = 16'(cmp_buf_q[k]);
          wb16[15:8]    = din;
          cmp_buf_d[k]  = wb16[WIDTH-1:0];
        end
      end
    end
  end

  // Prescaler, counter, compares and outputs
  always_comb begin
    pcnt_d    = pcnt_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    cmp_act_d = cmp_act_q;
    flag_set  = '0;
    if (!running) begin
      pcnt_d    = '0;
      cnt_d     = '0;
      out_d     = '0;
      cmp_act_d = cmp_buf_q;
    end else begin
      pcnt_d = tick ? 16'd0 : pcnt_q + 16'd1;
      // CTC follows the buffers continuously; PWM only reloads at the wrap
      // so a period never sees a half-updated duty.
      if (ctc_mode) begin
        cmp_act_d = cmp_buf_q;
      end
      if (tick && ctc_mode) begin
        if (cnt_q == cmp_act_q[0]) begin
          cnt_d       = '0;
          out_d[0]    = ~out_q[0];
          flag_set[7] = 1'b1;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
        for (int k = 1; k < CHANNELS; k++) begin
          if (cnt_q == cmp_act_q[k]) begin
            out_d[k] = ~out_q[k];
          end
        end
        for (int k = 0; k < CHANNELS; k++) begin
          if (cnt_q == cmp_act_q[k]) begin
            flag_set[k] = 1'b1;
          end
        end
      end else if (tick && pwm_mode) begin
        cnt_d = cnt_q + WIDTH'(1);
        if (cnt_q == MAX) begin
          // Set at the wrap wins over a compare of MAX: 100% duty.
          out_d       = '1;
          flag_set[7] = 1'b1;
          cmp_act_d   = cmp_buf_q;
        end else begin
          for (int k = 0; k < CHANNELS; k++) begin
            if (cnt_q == cmp_act_q[k]) begin
              out_d[k]    = 1'b0;
              flag_set[k] = 1'b1;
            end
          end
        end
      end
    end
    // A mode change restarts the timebase from a clean state.
    if (mode_chg) begin
      pcnt_d    = '0;
      cnt_d     = '0;
      out_d     = '0;
      cmp_act_d = cmp_buf_q;
    end
  end

  // Flags: W1C, but a hardware set on the same edge wins
  always_comb begin
    flags_d = flags_q;
    if (w_en && (address == 8'h05)) begin
      flags_d = flags_q & ~din;
    end
    flags_d = flags_d | flag_set;
  end

  // Read mux
  always_comb begin
    rdata = 8'h00;
    rb16  = '0;
    case (address)
      8'h00:   rdata = {6'b0, mode_q};
      8'h01:   rdata = outen_q;
      8'h02:   rdata = presc_q[7:0];
      8'h03:   rdata = presc_q[15:8];
      8'h04:   rdata = irqen_q;
      8'h05:   rdata = flags_q;
      8'h06:   rdata = cnt16[7:0];
      8'h07:   rdata = (WIDTH == 16) ? snap_q : 8'h00;
      default: ;
    endcase
    for (int k = 0; k < CHANNELS; k++) begin
      rb16 = 16'(cmp_buf_q[k]);
      if (address == 8'(8 + 2 * k)) begin
        rdata = rb16[7:0];
      end else if ((WIDTH == 16) && (address == 8'(9 + 2 * k))) begin
        rdata = rb16[15:8];
      end
    end
  end

  // Reading CNT_L freezes the high byte so a later CNT_H read is coherent.
  always_comb begin
    snap_d = snap_q;
    dout_d = dout_q;
    if (r_en) begin
      dout_d = rdata;
      if (address == 8'h06) begin
        snap_d = cnt16[15:8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= '0;
      outen_q <= '0;
      presc_q <= '0;
      irqen_q <= '0;
      flags_q <= '0;
      pcnt_q  <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      snap_q  <= '0;
      dout_q  <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        cmp_buf_q[k] <= '0;
        cmp_act_q[k] <= '0;
      end
    end else begin
      mode_q    <= mode_d;
      outen_q   <= outen_d;
      presc_q   <= presc_d;
      irqen_q   <= irqen_d;
      flags_q   <= flags_d;
      pcnt_q    <= pcnt_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      snap_q    <= snap_d;
      dout_q    <= dout_d;
      cmp_buf_q <= cmp_buf_d;
      cmp_act_q <= cmp_act_d;
    end
  end

  assign dout    = dout_q;
  assign pwm_out = out_q;
  assign pwm_en  = outen_q[CHANNELS-1:0];
  assign irq     = |(flags_q & irqen_q);

endmodule

// File: tb/tb_timer_pwm_multi.sv
// tb_timer_pwm_multi: drives an 8-bit and a 16-bit timer from one shared register bus
// and compares every cycle against a behavioural model, plus directed checks on duty,
// toggle period, double buffering, atomic count reads, flag races and reset.
module tb_timer_pwm_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din, address;
  logic       w_en, r_en;
  logic [7:0] dout8, dout16;
  logic [1:0] pwm8, pwm16, en8, en16;
  logic       irq8, irq16;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  // Behavioural model state, index 0 = WIDTH 8, index 1 = WIDTH 16
  int m_mode[2], m_outen[2], m_presc[2], m_irqen[2], m_flags[2];
  int m_pc[2], m_cnt[2], m_snap[2], m_dout[2];
  int m_buf[2][2], m_act[2][2], m_out[2][2];

  always #5 clk = ~clk;

  timer_pwm_multi #(.WIDTH(8), .CHANNELS(2)) u_dut8 (
    .clk(clk), .rst(rst), .din(din), .address(address), .w_en(w_en), .r_en(r_en),
    .dout(dout8), .pwm_out(pwm8), .pwm_en(en8), .irq(irq8)
  );

  timer_pwm_multi #(.WIDTH(16), .CHANNELS(2)) u_dut16 (
    .clk(clk), .rst(rst), .din(din), .address(address), .w_en(w_en), .r_en(r_en),
    .dout(dout16), .pwm_out(pwm16), .pwm_en(en16), .irq(irq16)
  );

  function automatic int wid(input int i);
    return (i == 0) ? 8 : 16;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_outen[i] = 0; m_presc[i] = 0; m_irqen[i] = 0; m_flags[i] = 0;
      m_pc[i] = 0; m_cnt[i] = 0; m_snap[i] = 0; m_dout[i] = 0;
      for (int k = 0; k < 2; k++) begin
        m_buf[i][k] = 0; m_act[i][k] = 0; m_out[i][k] = 0;
      end
    end
  endtask

  function automatic int model_read(input int i, input int a);
    case (a)
      0: return m_mode[i];
      1: return m_outen[i];
      2: return m_presc[i] & 255;
      3: return m_presc[i] >> 8;
      4: return m_irqen[i];
      5: return m_flags[i];
      6: return m_cnt[i] & 255;
      7: return (wid(i) == 16) ? m_snap[i] : 0;
      8, 10: return m_buf[i][(a - 8) / 2] & 255;
      9, 11: return (wid(i) == 16) ? (m_buf[i][(a - 9) / 2] >> 8) : 0;
      default: return 0;
    endcase
  endfunction

  // One clock edge of the timer, expressed from the register-level rules.
  task automatic model_step(input int i);
    int mx, a, d, nd, nsnap, nmode, nouten, npresc, nirqen, nflags, npc, ncnt, setm;
    int nbuf[2], nact[2], nout[2];
    bit we, re, chg, run, tk;
    mx = (1 << wid(i)) - 1;
    we = w_en; re = r_en; a = int'(address); d = int'(din);
    nd = m_dout[i]; nsnap = m_snap[i];
    nmode = m_mode[i]; nouten = m_outen[i]; npresc = m_presc[i]; nirqen = m_irqen[i];
    nflags = m_flags[i]; npc = m_pc[i]; ncnt = m_cnt[i]; setm = 0;
    for (int k = 0; k < 2; k++) begin
      nbuf[k] = m_buf[i][k]; nact[k] = m_act[i][k]; nout[k] = m_out[i][k];
    end
    if (re) begin
      nd = model_read(i, a);
      if (a == 6) nsnap = m_cnt[i] >> 8;
    end
    if (we) begin
      case (a)
        0: nmode = d & 3;
        1: nouten = d;
        2: npresc = (m_presc[i] & 'hFF00) | d;
        3: npresc = (m_presc[i] & 'hFF) | (d << 8);
        4: nirqen = d;
        5: nflags = m_flags[i] & ~d;
        8, 10: nbuf[(a - 8) / 2] = (m_buf[i][(a - 8) / 2] & 'hFF00) | d;
        9, 11: if (wid(i) == 16) nbuf[(a - 9) / 2] = (m_buf[i][(a - 9) / 2] & 'hFF) | (d << 8);
        default: ;
      endcase
    end
    chg = we && (a == 0) && ((d & 3) != m_mode[i]);
    run = (m_mode[i] == 1) || (m_mode[i] == 2);
    if (!run) begin
      npc = 0; ncnt = 0;
      for (int k = 0; k < 2; k++) begin nout[k] = 0; nact[k] = m_buf[i][k]; end
    end else begin
      tk = (m_pc[i] >= m_presc[i]);
      npc = tk ? 0 : m_pc[i] + 1;
      if (m_mode[i] == 1) for (int k = 0; k < 2; k++) nact[k] = m_buf[i][k];
      if (tk && m_mode[i] == 1) begin
        if (m_cnt[i] == m_act[i][0]) begin
          ncnt = 0; nout[0] = 1 - m_out[i][0]; setm |= 'h80;
        end else begin
          ncnt = (m_cnt[i] + 1) & mx;
        end
        if (m_cnt[i] == m_act[i][1]) nout[1] = 1 - m_out[i][1];
        for (int k = 0; k < 2; k++) if (m_cnt[i] == m_act[i][k]) setm |= (1 << k);
      end else if (tk) begin
        ncnt = (m_cnt[i] + 1) & mx;
        if (m_cnt[i] == mx) begin
          setm |= 'h80;
          for (int k = 0; k < 2; k++) begin nout[k] = 1; nact[k] = m_buf[i][k]; end
        end else begin
          for (int k = 0; k < 2; k++) begin
            if (m_cnt[i] == m_act[i][k]) begin nout[k] = 0; setm |= (1 << k); end
          end
        end
      end
    end
    if (chg) begin
      npc = 0; ncnt = 0;
      for (int k = 0; k < 2; k++) begin nout[k] = 0; nact[k] = m_buf[i][k]; end
    end
    nflags |= setm;
    m_dout[i] = nd; m_snap[i] = nsnap; m_mode[i] = nmode; m_outen[i] = nouten;
    m_presc[i] = npresc; m_irqen[i] = nirqen; m_flags[i] = nflags; m_pc[i] = npc; m_cnt[i] = ncnt;
    for (int k = 0; k < 2; k++) begin
      m_buf[i][k] = nbuf[k]; m_act[i][k] = nact[k]; m_out[i][k] = nout[k];
    end
  endtask

  task automatic check_outputs();
    check($sformatf("dout8@%0d", cyc), 16'(dout8), 16'(m_dout[0]));
    check($sformatf("dout16@%0d", cyc), 16'(dout16), 16'(m_dout[1]));
    check($sformatf("pwm8@%0d", cyc), 16'(pwm8), 16'(m_out[0][0] | (m_out[0][1] << 1)));
    check($sformatf("pwm16@%0d", cyc), 16'(pwm16), 16'(m_out[1][0] | (m_out[1][1] << 1)));
    check($sformatf("en8@%0d", cyc), 16'(en8), 16'(m_outen[0] & 3));
    check($sformatf("en16@%0d", cyc), 16'(en16), 16'(m_outen[1] & 3));
    check($sformatf("irq8@%0d", cyc), 16'(irq8), 16'((m_flags[0] & m_irqen[0]) != 0));
    check($sformatf("irq16@%0d", cyc), 16'(irq16), 16'((m_flags[1] & m_irqen[1]) != 0));
  endtask

  // Inputs are stable at the posedge (driven at negedge), so the model
  // samples them there; DUT outputs are compared at the following negedge.
  task automatic tick_clk();
    @(posedge clk);
    if (rst) model_reset();
    else begin model_step(0); model_step(1); end
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic wr(input int a, input int d);
    address = 8'(a); din = 8'(d); w_en = 1'b1;
    tick_clk();
    w_en = 1'b0;
  endtask

  task automatic rd(input int a);
    address = 8'(a); r_en = 1'b1;
    tick_clk();
    r_en = 1'b0;
  endtask

  task automatic wait_cnt(input int i, input int val, input int budget, input string tag);
    int n;
    n = 0;
    while (m_cnt[i] != val && n < budget) begin tick_clk(); n++; end
    check(tag, 16'(m_cnt[i]), 16'(val));
  endtask

  task automatic measure_high(output int len);
    int n;
    n = 0; len = 0;
    while (pwm8[0] === 1'b1 && n < 1200) begin tick_clk(); n++; end
    while (pwm8[0] === 1'b0 && n < 1200) begin tick_clk(); n++; end
    while (pwm8[0] === 1'b1 && n < 1200) begin tick_clk(); n++; len++; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, last, nt, hi0, hi1, len, op, a, d;
    logic prev;
    rst = 1'b1; din = '0; address = '0; w_en = 1'b0; r_en = 1'b0;
    model_reset();
    repeat (2) tick_clk();
    rst = 1'b0;
    check("rst_dout8", 16'(dout8), 16'h0);
    check("rst_pwm16", 16'(pwm16), 16'h0);
    check("rst_irq8", 16'(irq8), 16'h0);

    // Reset mid-PWM
    wr(8, 'h34); wr(9, 'h12); wr(1, 3); wr(4, 'h80); wr(0, 2);
    repeat (300) tick_clk();
    rd(8);
    check("pre_rst_irq8", 16'(irq8), 16'h1);
    check("pre_rst_dout16", 16'(dout16), 16'h34);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("arst_dout8", 16'(dout8), 16'h0);
    check("arst_dout16", 16'(dout16), 16'h0);
    check("arst_pwm8", 16'(pwm8), 16'h0);
    check("arst_pwm16", 16'(pwm16), 16'h0);
    check("arst_en16", 16'(en16), 16'h0);
    check("arst_irq8", 16'(irq8), 16'h0);
    check("arst_irq16", 16'(irq16), 16'h0);
    tick_clk();
    rst = 1'b0;
    rd(6); check("rst_cnt_l", 16'(dout16), 16'h0);
    rd(7); check("rst_cnt_h", 16'(dout16), 16'h0);

    // CTC: toggle every 5 cycles, wrap flag and interrupt
    wr(8, 4); wr(10, 'h10); wr(4, 'h80); wr(0, 1);
    first = cyc; last = -1; nt = 0; prev = pwm8[0];
    for (int n = 0; n < 40; n++) begin
      tick_clk();
      if (pwm8[0] !== prev) begin
        prev = pwm8[0];
        if (last < 0) check("ctc_first_toggle", 16'(cyc - first), 16'd5);
        else if (nt < 3) begin check($sformatf("ctc_period%0d", nt), 16'(cyc - last), 16'd5); nt++; end
        last = cyc;
      end
    end
    check("ctc_toggle_count", 16'(nt), 16'd3);
    rd(5);
    check("ctc_flag7", 16'(dout8 & 8'h80), 16'h80);
    check("ctc_irq", 16'(irq8), 16'h1);
    wr(0, 0); wr(5, 'h80);
    check("w1c_irq", 16'(irq8), 16'h0);

    // PWM: PRESC=1, 0x3F -> 128/512 high, 0xFF -> constant 1
    wr(2, 1); wr(8, 'h3F); wr(10, 'hFF); wr(0, 2);
    repeat (520) tick_clk();
    hi0 = 0; hi1 = 0;
    for (int n = 0; n < 512; n++) begin
      tick_clk();
      hi0 += int'(pwm8[0]); hi1 += int'(pwm8[1]);
    end
    check("pwm_duty_3f", 16'(hi0), 16'd128);
    check("pwm_duty_ff", 16'(hi1), 16'd512);

    // Double buffer: mid-period update only applies from the next period
    wait_cnt(0, 'h10, 600, "wait_cnt10");
    wr(8, 'hBF);
    wait_cnt(0, 'h50, 300, "wait_cnt50");
    check("dbuf_old_duty", 16'(pwm8[0]), 16'h0);
    measure_high(len);
    check("dbuf_new_duty", 16'(len), 16'd384);

    // Atomic count read on the 16-bit timer
    wr(0, 0); wr(2, 0); wr(0, 2);
    wait_cnt(1, 'h1FF, 700, "wait_cnt1ff");
    rd(6);
    check("atomic_cnt_l", 16'(dout16), 16'hFF);
    repeat (3) tick_clk();
    rd(7);
    check("atomic_cnt_h", 16'(dout16), 16'h01);

    // Flag race: W1C on the edge of a channel 0 match, set wins
    wr(0, 0); wr(8, 4); wr(5, 'hFF); wr(0, 1);
    wait_cnt(0, 4, 20, "wait_cnt4");
    wr(5, 'h01);
    rd(5);
    check("race_flag0", 16'(dout8 & 8'h01), 16'h01);
    rd('h0C);
    check("unmapped8", 16'(dout8), 16'h0);
    check("unmapped16", 16'(dout16), 16'h0);

    // Randomised register traffic against the model
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 3);
      d = $urandom_range(0, 255);
      if (op == 0) tick_clk();
      else if (op == 1) begin
        a = $urandom_range(0, 11);
        if (a == 2) d = d & 7;
        if (a == 3) d = 0;
        wr(a, d);
      end else begin
        a = $urandom_range(0, 15);
        rd(a);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
